frame_scheduler: RTL
====================

Name: frame_scheduler

Overview:
- Sequences game-logic updates against the VGA raster.
- Watches the raster counters from the VGA timing generator.
- Emits a per-frame tick at the start of vertical blanking.
- Issues a req/ack/done handshake to the game-state update engine once every (speed_div+1) frames, so sprite, pipe and score state changes only outside the visible area.
- Flags overruns, where an update is still running when the next visible frame begins.

Parameters:
- H_TOTAL, 800: pixels per line, including blanking.
- V_DISPLAY, 480: visible lines.
- V_TOTAL, 525: lines per frame, including blanking.
- DIV_WIDTH, 4: width of the speed_div input and of the internal frame divider.

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; asynchronous, active-high
- h_pos  in  16  current raster column from the timing generator
- v_pos  in  16  current raster line from the timing generator
- enable  in  1  allows new update issues
- speed_div  in  DIV_WIDTH  frames to skip between updates; 0 means every frame
- upd_req  out  1  update request to the game engine, level signal
- upd_ack  in  1  engine accepts the request
- upd_done  in  1  one-cycle pulse when the engine finishes
- frame_tick  out  1  one-cycle pulse at the start of vblank
- vblank  out  1  high while v_pos >= V_DISPLAY (registered)
- frame_cnt  out  16  count of frame ticks, wraps
- busy  out  1  high when the FSM is not IDLE
- overrun  out  1  one-cycle pulse when a visible frame starts while busy

Behaviour:
- Reset (asynchronous, active-high): all outputs are 0, FSM is IDLE, divider is 0. Reset asserted mid-handshake drops upd_req immediately; any in-flight update is abandoned.
- Raster events are decoded by exact compare only; out-of-range h_pos/v_pos values never fire an event.
  - vb_evt = (h_pos == H_TOTAL-1) && (v_pos == V_DISPLAY-1).
  - disp_evt = (h_pos == H_TOTAL-1) && (v_pos == V_TOTAL-1).
- vblank is registered: 1 cycle latency from the v_pos input.
- frame_tick:
  - Asserted for exactly 1 cycle, on the edge after vb_evt.
  - frame_cnt increments on the same edge and wraps 0xFFFF -> 0x0000.
- Divider:
  - speed_div is sampled on the frame_tick edge.
  - If div_cnt >= sampled speed_div: issue = 1 and div_cnt <= 0. Otherwise div_cnt increments.
  - The divider advances regardless of enable or FSM state.
- FSM, IDLE/REQ/BUSY:
  - IDLE: if issue && enable -> REQ. upd_req rises the cycle after frame_tick.
  - REQ: upd_req = 1.
    - upd_ack -> BUSY, with upd_req low from the next cycle.
    - upd_ack && upd_done in the same cycle -> IDLE directly.
  - BUSY: upd_done -> IDLE.
  - upd_done seen in IDLE is ignored.
  - upd_ack seen outside REQ is ignored.
- An issue while not IDLE is dropped; it is not queued.
- enable = 0 blocks new REQ entries only. An in-flight handshake completes normally, and frame_tick/frame_cnt keep running.
- overrun:
  - 1-cycle pulse on the edge after disp_evt if the FSM is REQ or BUSY.
  - The FSM state is unaffected; the update continues.
- busy = (state != IDLE), registered alongside the state.

Optional Feature:
- Macro: FRAME_SCHED_OVERRUN_CNT_EN.
- Defined:
  - Adds output overrun_cnt, 8 bits.
  - It increments on each overrun pulse and saturates at 0xFF; it does not wrap.
  - It resets to 0 on rst, and also when enable goes 0->1 (edge detected internally).
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then free-run the raster with enable = 1 and speed_div = 0 -> frame_tick fires once per 420000 clocks, one cycle after (799,479); frame_cnt reads 1, 2, 3; vblank rises one cycle after v_pos reaches 480.
- speed_div = 2, engine acks after 3 cycles and sends done 10 cycles later -> upd_req asserts on frames 3, 6, 9 only; busy is high for 14 cycles per update; overrun stays 0.
- Engine withholds done past raster (799,524) -> overrun pulses exactly once that cycle; busy stays 1. A done pulse then arrives on line 10 -> IDLE; the next vblank issues normally.
- Done withheld for 2 whole frames with speed_div = 0 -> the second issue is dropped (no new upd_req rise); 2 overrun pulses occur; frame_cnt keeps incrementing.
- enable = 0 asserted while in REQ -> upd_req holds until ack, then completes. No further requests while enable = 0; the first frame after re-enable with the divider at terminal count issues a request.
- Assert rst while in BUSY mid-line -> upd_req, busy, frame_cnt and overrun go 0 without waiting for a clock edge. With the macro defined, 300 overruns make overrun_cnt read 0xFF.

Source files
------------

// File: rtl/frame_scheduler.sv
// frame_scheduler: paces game-state updates against the VGA raster.
// Decodes start-of-vblank and start-of-display from the raster counters,
// emits a per-frame tick, and runs a req/ack/done handshake with the
// update engine once every (speed_div+1) frames. If an update is still
// in progress when the visible area starts again, it flags an overrun.
// Optional feature macro: FRAME_SCHED_OVERRUN_CNT_EN adds an 8-bit
// saturating overrun counter output (overrun_cnt).
module frame_scheduler #(
    parameter int H_TOTAL   = 800,
    parameter int V_DISPLAY = 480,
    parameter int V_TOTAL   = 525,
    parameter int DIV_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          h_pos,
    input  logic [15:0]          v_pos,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] speed_div,
    output logic                 upd_req,
    input  logic                 upd_ack,
    input  logic                 upd_done,
    output logic                 frame_tick,
    output logic                 vblank,
    output logic [15:0]          frame_cnt,
    output logic                 busy,
    output logic                 overrun
`ifdef FRAME_SCHED_OVERRUN_CNT_EN
    ,
    output logic [7:0]           overrun_cnt
`endif
);

    localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_VIS   = 16'(V_DISPLAY);
    localparam logic [15:0] V_VLAST = 16'(V_DISPLAY - 1);
    localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 issue;
    logic                 vb_evt, disp_evt, ovr_set;

    // Exact-compare raster decode; anything out of range never matches.
    assign vb_evt   = (h_pos == H_LAST) && (v_pos == V_VLAST);
    assign disp_evt = (h_pos == H_LAST) && (v_pos == V_LAST);
    assign ovr_set  = disp_evt && (state != IDLE);

    // Raster-derived outputs: vblank flag, frame tick and frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblank     <= 1'b0;
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
            overrun    <= 1'b0;
        end else begin
            vblank     <= (v_pos >= V_VIS);
            frame_tick <= vb_evt;
            overrun    <= ovr_set;
            if (vb_evt)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Frame divider: decides on each tick edge whether this frame updates.
    // It keeps running regardless of enable or FSM state, so a disabled or
    // busy period does not shift the update cadence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            issue   <= 1'b0;
        end else begin
            issue <= 1'b0;
            if (vb_evt) begin
                if (div_cnt >= speed_div) begin
                    issue   <= 1'b1;
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

    // Handshake state register; busy is registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    // Next-state and request decode. Issues arriving outside IDLE are dropped.
    always_comb begin
        state_nxt = state;
        upd_req   = 1'b0;
        case (state)
            IDLE: begin
                if (issue && enable)
                    state_nxt = REQ;
            end
            REQ: begin
                upd_req = 1'b1;
                if (upd_ack)
                    state_nxt = upd_done ? IDLE : BUSY;
            end
            BUSY: begin
                if (upd_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FRAME_SCHED_OVERRUN_CNT_EN
    logic en_q;

    // Saturating overrun counter, cleared on a rising edge of enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q        <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            en_q <= enable;
            if (enable && !en_q)
                overrun_cnt <= '0;
            else if (ovr_set && (overrun_cnt != 8'hFF))
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

endmodule
